segment_capture_sequencer: RTL and testbench

SEGMENT_CAPTURE_SEQUENCER -- requirements
Module: segment_capture_sequencer

---
 rtl/segment_capture_sequencer.sv | 173 +++++++++++++++++
 tb/tb_segment_capture_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_capture_sequencer.sv
// Segment capture sequencer: arms on an arm_i rising edge, then runs triggered or timed sample segments.
// Latency: capture_go_o/segment_start_o assert one cycle after the trigger edge; all outputs are registered.
// Backpressure: fifo_full_i stalls sampling, or aborts with overflow_o when SEGSEQ_OVERFLOW_ABORT_EN is defined.
module segment_capture_sequencer #(
    parameter int pSEG_WIDTH  = 16,
    parameter int pCYC_WIDTH  = 20,
    parameter int pSAMP_WIDTH = 32
) (
    input  logic                   adc_sampleclk,
    input  logic                   reset_n,
    input  logic                   arm_i,
    input  logic                   trigger_i,
    input  logic [pSEG_WIDTH-1:0]  num_segments_i,
    input  logic [pCYC_WIDTH-1:0]  segment_cycles_i,
    input  logic                   segment_cycle_counter_en_i,
    input  logic [pSAMP_WIDTH-1:0] samples_i,
    input  logic                   fifo_full_i,
    output logic                   capture_go_o,
    output logic                   segment_start_o,
    output logic                   segment_done_o,
    output logic                   capture_done_o,
    output logic                   armed_o,
    output logic                   overflow_o,
    output logic [pSEG_WIDTH-1:0]  segment_count_o,
    output logic [2:0]             state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TRIG = 3'd1,
        S_CAPTURE   = 3'd2,
        S_GAP       = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                 state;
    logic                   arm_q;
    logic [pSEG_WIDTH-1:0]  nseg_q;
    logic [pCYC_WIDTH-1:0]  cyc_q;
    logic [pSAMP_WIDTH-1:0] samp_q;
    logic                   timed_q;
    logic [pSAMP_WIDTH-1:0] samp_left;
    logic [pCYC_WIDTH-1:0]  per_cnt;

    logic                   arm_rise;
    logic                   last_seg;
    logic                   period_due;
    logic                   abort_ovf;
    logic                   stall;
    logic                   start_seg;
    logic [pSEG_WIDTH-1:0]  count_inc;

    assign state_o    = state;
    assign arm_rise   = arm_i & ~arm_q;
    assign last_seg   = (segment_count_o == nseg_q);
    assign count_inc  = (&segment_count_o) ? segment_count_o : segment_count_o + 1'b1;
    // per_cnt is 0 in a segment's start cycle, so the next start is due once per_cnt+1 reaches the period
    assign period_due = ({1'b0, per_cnt} + 1'b1) >= {1'b0, cyc_q};

`ifdef SEGSEQ_OVERFLOW_ABORT_EN
    assign abort_ovf = capture_go_o & fifo_full_i;
    assign stall     = 1'b0;
`else
    assign abort_ovf = 1'b0;
    assign stall     = fifo_full_i;
`endif

    assign start_seg = arm_i && (
        (state == S_WAIT_TRIG && trigger_i) ||
        (state == S_GAP && period_due) ||
        (state == S_CAPTURE && segment_done_o && !abort_ovf && !last_seg && timed_q && period_due));

    always_ff @(posedge adc_sampleclk) begin
        // arm history follows arm_i through reset so a level held across release is not an edge
        arm_q <= arm_i;
        if (!reset_n) begin
            state           <= S_IDLE;
            capture_go_o    <= 1'b0;
            segment_start_o <= 1'b0;
            segment_done_o  <= 1'b0;
            capture_done_o  <= 1'b0;
            armed_o         <= 1'b0;
            overflow_o      <= 1'b0;
            segment_count_o <= '0;
            nseg_q          <= '0;
            cyc_q           <= '0;
            samp_q          <= '0;
            timed_q         <= 1'b0;
            samp_left       <= '0;
            per_cnt         <= '0;
        end else begin
            segment_start_o <= 1'b0;
            segment_done_o  <= 1'b0;
            capture_done_o  <= 1'b0;
            if (per_cnt != '1) per_cnt <= per_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (arm_rise) begin
                        state           <= S_WAIT_TRIG;
                        armed_o         <= 1'b1;
                        segment_count_o <= '0;
                        overflow_o      <= 1'b0;
                        nseg_q          <= (num_segments_i == '0) ? pSEG_WIDTH'(1) : num_segments_i;
                        samp_q          <= (samples_i == '0) ? pSAMP_WIDTH'(1) : samples_i;
                        cyc_q           <= segment_cycles_i;
                        timed_q         <= segment_cycle_counter_en_i;
                    end
                end
                S_WAIT_TRIG, S_GAP: begin
                    if (!arm_i) begin
                        state   <= S_IDLE;
                        armed_o <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    if (!arm_i) begin
                        state        <= S_IDLE;
                        armed_o      <= 1'b0;
                        capture_go_o <= 1'b0;
                    end else if (abort_ovf) begin
                        overflow_o     <= 1'b1;
                        capture_go_o   <= 1'b0;
                        state          <= S_DONE;
                        armed_o        <= 1'b0;
                        capture_done_o <= 1'b1;
                    end else if (segment_done_o) begin
                        capture_go_o <= 1'b0;
                        if (last_seg) begin
                            state          <= S_DONE;
                            armed_o        <= 1'b0;
                            capture_done_o <= 1'b1;
                        end else if (timed_q) begin
                            state <= S_GAP;
                        end else begin
                            state <= S_WAIT_TRIG;
                        end
                    end else if (stall) begin
                        capture_go_o <= 1'b0;
                    end else begin
                        capture_go_o <= 1'b1;
                        samp_left    <= samp_left - 1'b1;
                        if (samp_left == pSAMP_WIDTH'(1)) begin
                            segment_done_o  <= 1'b1;
                            segment_count_o <= count_inc;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    state        <= S_IDLE;
                    armed_o      <= 1'b0;
                    capture_go_o <= 1'b0;
                end
            endcase

            // segment start overrides the per-state transitions above
            if (start_seg) begin
                state           <= S_CAPTURE;
                armed_o         <= 1'b1;
                capture_go_o    <= 1'b1;
                segment_start_o <= 1'b1;
                per_cnt         <= '0;
                samp_left       <= samp_q - 1'b1;
                if (samp_q == pSAMP_WIDTH'(1)) begin
                    segment_done_o  <= 1'b1;
                    segment_count_o <= count_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_segment_capture_sequencer.sv
// Bench for segment_capture_sequencer: directed vector table, hand-written corner sequences,
// and random captures checked against a segment-timeline model.
module tb_segment_capture_sequencer;

    localparam int W = 160;
    localparam int A = 3;

    logic        adc_sampleclk = 1'b0;
    logic        reset_n;
    logic        arm_i;
    logic        trigger_i;
    logic [15:0] num_segments_i;
    logic [19:0] segment_cycles_i;
    logic        segment_cycle_counter_en_i;
    logic [31:0] samples_i;
    logic        fifo_full_i;
    logic        capture_go_o, segment_start_o, segment_done_o, capture_done_o, armed_o, overflow_o;
    logic [15:0] segment_count_o;
    logic [2:0]  state_o;

    segment_capture_sequencer dut (
        .adc_sampleclk              (adc_sampleclk),
        .reset_n                    (reset_n),
        .arm_i                      (arm_i),
        .trigger_i                  (trigger_i),
        .num_segments_i             (num_segments_i),
        .segment_cycles_i           (segment_cycles_i),
        .segment_cycle_counter_en_i (segment_cycle_counter_en_i),
        .samples_i                  (samples_i),
        .fifo_full_i                (fifo_full_i),
        .capture_go_o               (capture_go_o),
        .segment_start_o            (segment_start_o),
        .segment_done_o             (segment_done_o),
        .capture_done_o             (capture_done_o),
        .armed_o                    (armed_o),
        .overflow_o                 (overflow_o),
        .segment_count_o            (segment_count_o),
        .state_o                    (state_o)
    );

    always #5 adc_sampleclk = ~adc_sampleclk;

    typedef struct packed {
        int nseg; int samp; int cyc; int timed;
        int e_go; int e_sd; int e_cnt; int e_per; int e_run;
    } vec_t;

    vec_t vt [6];
    int   n_cmp = 0;
    int   n_fail = 0;

    int   e_st [W];
    bit   e_go [W], e_ss [W], e_sd [W], e_cd [W];
    int   e_cnt [W];
    bit   trig [W];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge adc_sampleclk);
    endtask

    function automatic longint all_outs();
        return {state_o, armed_o, capture_go_o, segment_start_o, segment_done_o,
                capture_done_o, overflow_o, segment_count_o};
    endfunction

    task automatic set_cfg(input int n, input int s, input int c, input int t);
        num_segments_i             = 16'(n);
        samples_i                  = 32'(s);
        segment_cycles_i           = 20'(c);
        segment_cycle_counter_en_i = t[0];
    endtask

    task automatic rnd_cfg();
        num_segments_i             = 16'($urandom);
        samples_i                  = $urandom;
        segment_cycles_i           = 20'($urandom);
        segment_cycle_counter_en_i = 1'($urandom);
    endtask

    // Timeline model: arm edge -> wait for trigger -> segments placed by start time arithmetic
    task automatic build_model(input int n, input int s, input int c, input int tm);
        int neff, seff, per, cur, k, start, prev_start, t;
        for (int i = 0; i < W; i++) begin
            e_st[i] = 0; e_go[i] = 0; e_ss[i] = 0; e_sd[i] = 0; e_cd[i] = 0; e_cnt[i] = 0;
        end
        neff = (n == 0) ? 1 : n;
        seff = (s == 0) ? 1 : s;
        per  = (c > seff) ? c : seff;
        cur = A + 1; k = 0; prev_start = 0; start = 0;
        while (cur < W) begin
            if (k == 0 || tm == 0) begin
                t = cur;
                while (t < W && !trig[t]) begin e_st[t] = 1; t++; end
                if (t >= W) break;
                e_st[t] = 1;
                start = t + 1;
            end else begin
                start = prev_start + per;
                for (int i = cur; i < start && i < W; i++) e_st[i] = 3;
            end
            for (int j = 0; j < seff; j++)
                if (start + j < W) begin e_st[start + j] = 2; e_go[start + j] = 1; end
            if (start < W) e_ss[start] = 1;
            if (start + seff - 1 < W) begin
                e_sd[start + seff - 1] = 1;
                for (int i = start + seff - 1; i < W; i++) e_cnt[i] = k + 1;
            end
            k++;
            prev_start = start;
            cur = start + seff;
            if (k == neff) begin
                if (cur < W) begin e_st[cur] = 4; e_cd[cur] = 1; end
                break;
            end
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int gocnt, sdcnt, cdcnt, run, maxrun, prev_ss, badgap, post, cyc;
        bit seen;
        gocnt = 0; sdcnt = 0; cdcnt = 0; run = 0; maxrun = 0; prev_ss = -1; badgap = 0;
        post = 0; seen = 0;
        arm_i = 0; trigger_i = 0; fifo_full_i = 0;
        set_cfg(v.nseg, v.samp, v.cyc, v.timed);
        tick(); tick();
        arm_i = 1;
        tick();
        rnd_cfg();
        trigger_i = 1;
        for (cyc = 0; cyc < 400; cyc++) begin
            tick();
            if (capture_go_o) begin
                gocnt++; run++;
                if (run > maxrun) maxrun = run;
            end else run = 0;
            if (segment_start_o) begin
                if (prev_ss >= 0 && v.e_per != 0 && cyc - prev_ss != v.e_per) badgap++;
                prev_ss = cyc;
            end
            if (segment_done_o) sdcnt++;
            if (capture_done_o) begin cdcnt++; seen = 1; end
            if (v.timed != 0) trigger_i = 0;
            if (seen) begin
                post++;
                if (post > 3) break;
            end
        end
        chk($sformatf("vec%0d.done_seen", idx), seen, 1);
        chk($sformatf("vec%0d.go_cycles", idx), gocnt, v.e_go);
        chk($sformatf("vec%0d.seg_done", idx), sdcnt, v.e_sd);
        chk($sformatf("vec%0d.cap_done", idx), cdcnt, 1);
        chk($sformatf("vec%0d.seg_count", idx), segment_count_o, v.e_cnt);
        chk($sformatf("vec%0d.bad_period", idx), badgap, 0);
        chk($sformatf("vec%0d.max_run", idx), maxrun, v.e_run);
        arm_i = 0; trigger_i = 0;
        tick(); tick();
    endtask

    initial begin
        int gocnt, first, last, fl, post, bad, n, s, c, tm;
        bit hit, seen, ovf, armed_fl, fl_done;

        //             nseg samp cyc timed  go sd cnt per run
        vt[0] = '{3,   4,   0,  0,    12, 3, 3,  0,  4};
        vt[1] = '{4,   10,  25, 1,    40, 4, 4,  25, 10};
        vt[2] = '{2,   8,   5,  1,    16, 2, 2,  8,  16};
        vt[3] = '{0,   0,   0,  0,    1,  1, 1,  0,  1};
        vt[4] = '{3,   5,   5,  1,    15, 3, 3,  5,  15};
        vt[5] = '{3,   5,   6,  1,    15, 3, 3,  6,  5};

        reset_n = 0; arm_i = 1; trigger_i = 0; fifo_full_i = 0;
        set_cfg(1, 1, 0, 0);
        tick(); tick(); tick();
        chk("reset_state", all_outs(), 0);
        reset_n = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("arm_high_at_release", state_o, 0);
        end
        arm_i = 0; tick(); tick();

        for (int i = 0; i < 6; i++) run_vec(i, vt[i]);

        // arm dropped on the third sample of the second segment
        set_cfg(3, 6, 0, 0);
        arm_i = 1; trigger_i = 1;
        gocnt = 0; hit = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (capture_go_o) gocnt++;
            if (gocnt == 9 && capture_go_o) begin arm_i = 0; hit = 1; break; end
        end
        chk("abort_reached", hit, 1);
        tick();
        chk("abort_state", state_o, 0);
        chk("abort_go", capture_go_o, 0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (capture_done_o || segment_done_o) seen = 1;
            tick();
        end
        chk("abort_no_done", seen, 0);
        chk("abort_count", segment_count_o, 1);
        trigger_i = 0;

        // arm held high after DONE must not re-arm
        set_cfg(1, 2, 0, 0);
        tick();
        arm_i = 1; tick(); trigger_i = 1;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (capture_done_o) seen = 1;
        end
        chk("rearm_done_seen", seen, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (state_o != 0 || capture_go_o) bad++;
        end
        chk("no_rearm", bad, 0);
        arm_i = 0; trigger_i = 0; tick(); tick();

        // reset in the middle of a capture, arm held high through release
        set_cfg(2, 8, 0, 0);
        arm_i = 1; tick(); trigger_i = 1;
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state_o == 3'd2) begin hit = 1; break; end
        end
        chk("reach_capture", hit, 1);
        reset_n = 0;
        tick();
        chk("reset_mid_capture", all_outs(), 0);
        tick();
        reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_arm_after_reset", state_o, 0);
        end
        arm_i = 0; trigger_i = 0; tick(); tick();

        for (int scen = 0; scen < 40; scen++) begin
            n  = $urandom_range(0, 4);
            s  = $urandom_range(0, 6);
            c  = $urandom_range(0, 15);
            tm = $urandom_range(0, 1);
            for (int i = 0; i < W; i++) trig[i] = ($urandom_range(0, 5) == 0);
            build_model(n, s, c, tm);
            for (int i = 0; i < W; i++) begin
                tick();
                if (i >= 1) begin
                    chk($sformatf("rnd%0d.cyc%0d.ctl", scen, i),
                        {state_o, armed_o, capture_go_o, segment_start_o, segment_done_o,
                         capture_done_o, overflow_o},
                        {3'(e_st[i]), (e_st[i] >= 1 && e_st[i] <= 3), e_go[i], e_ss[i],
                         e_sd[i], e_cd[i], 1'b0});
                    if (i >= A + 1)
                        chk($sformatf("rnd%0d.cyc%0d.count", scen, i), segment_count_o, e_cnt[i]);
                end
                arm_i = (i >= A);
                trigger_i = trig[i];
                fifo_full_i = 0;
                if (i <= A) set_cfg(n, s, c, tm);
                else rnd_cfg();
            end
        end
        arm_i = 0; trigger_i = 0; tick(); tick();

        // FIFO full for three cycles starting on the second sample
        set_cfg(1, 6, 0, 0);
        arm_i = 1; tick(); trigger_i = 1;
        gocnt = 0; first = -1; last = -1; fl = 0; post = 0; seen = 0; ovf = 0;
        armed_fl = 0; fl_done = 0;
        for (int i = 0; i < 60 && !fl_done; i++) begin
            tick();
            if (capture_go_o) begin
                gocnt++;
                if (first < 0) first = i;
                last = i;
            end
            if (overflow_o) ovf = 1;
            if (capture_done_o) seen = 1;
            if (gocnt == 2 && capture_go_o && !armed_fl) begin fl = 3; armed_fl = 1; end
            fifo_full_i = (fl > 0);
            if (fl > 0) fl--;
            if (seen) begin
                post++;
                if (post > 2) fl_done = 1;
            end
        end
        chk("ovf_done_seen", seen, 1);
`ifdef SEGSEQ_OVERFLOW_ABORT_EN
        chk("ovf_go_cycles", gocnt, 2);
        chk("ovf_flag", ovf, 1);
        chk("ovf_state_idle", state_o, 0);
`else
        chk("ovf_go_cycles", gocnt, 6);
        chk("ovf_go_span", last - first + 1, 9);
        chk("ovf_flag", ovf, 0);
`endif
        arm_i = 0; trigger_i = 0; fifo_full_i = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
